// File: rtl/demux2_buf_if.sv
// Handshake bundle for demux2_buf: one producer stream in, two consumer channels out.
// The producer and both consumers use the master modport; the demux itself uses the slave modport.
interface demux2_buf_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sel;

  logic             A_valid;
  logic             A_ready;
  logic [WIDTH-1:0] A_out;

  logic             B_valid;
  logic             B_ready;
  logic [WIDTH-1:0] B_out;

  modport master (
    output in_valid,
    output in_data,
    output sel,
    output A_ready,
    output B_ready,
    input  in_ready,
    input  A_valid,
    input  A_out,
    input  B_valid,
    input  B_out
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  sel,
    input  A_ready,
    input  B_ready,
    output in_ready,
    output A_valid,
    output A_out,
    output B_valid,
    output B_out
  );
endinterface

// File: rtl/demux2_buf.sv
// Registered 1-to-2 demultiplexer. Each output channel owns a 2-entry FIFO,
// so a stalled consumer only blocks words whose sel targets that channel.
module demux2_buf #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  demux2_buf_if.slave bus
);

  logic [1:0]            count_a_q, count_a_d;
  logic                  wr_ptr_a_q, wr_ptr_a_d;
  logic                  rd_ptr_a_q, rd_ptr_a_d;
  logic [1:0][WIDTH-1:0] mem_a_q, mem_a_d;

  logic [1:0]            count_b_q, count_b_d;
  logic                  wr_ptr_b_q, wr_ptr_b_d;
  logic                  rd_ptr_b_q, rd_ptr_b_d;
  logic [1:0][WIDTH-1:0] mem_b_q, mem_b_d;

  logic full_a, full_b;
  logic push_a, push_b;
  logic pop_a, pop_b;

  // in_ready depends only on sel and registered counts, never on the consumer readies.
  assign full_a       = (count_a_q == 2'd2);
  assign full_b       = (count_b_q == 2'd2);
  assign bus.in_ready = bus.sel ? ~full_b : ~full_a;

  assign push_a = bus.in_valid & ~bus.sel & ~full_a;
  assign push_b = bus.in_valid &  bus.sel & ~full_b;

  assign bus.A_valid = (count_a_q != 2'd0);
  assign bus.B_valid = (count_b_q != 2'd0);
  assign bus.A_out   = mem_a_q[rd_ptr_a_q];
  assign bus.B_out   = mem_b_q[rd_ptr_b_q];

  assign pop_a = bus.A_valid & bus.A_ready;
  assign pop_b = bus.B_valid & bus.B_ready;

  always_comb begin
    count_a_d  = count_a_q;
    wr_ptr_a_d = wr_ptr_a_q;
    rd_ptr_a_d = rd_ptr_a_q;
    mem_a_d    = mem_a_q;
    if (push_a) begin
      mem_a_d[wr_ptr_a_q] = bus.in_data;
      wr_ptr_a_d          = ~wr_ptr_a_q;
    end
    if (pop_a) begin
      rd_ptr_a_d = ~rd_ptr_a_q;
    end
    case ({push_a, pop_a})
      2'b10:   count_a_d = count_a_q + 2'd1;
      2'b01:   count_a_d = count_a_q - 2'd1;
      default: count_a_d = count_a_q;
    endcase
  end

  always_comb begin
    count_b_d  = count_b_q;
    wr_ptr_b_d = wr_ptr_b_q;
    rd_ptr_b_d = rd_ptr_b_q;
    mem_b_d    = mem_b_q;
    if (push_b) begin
      mem_b_d[wr_ptr_b_q] = bus.in_data;
      wr_ptr_b_d          = ~wr_ptr_b_q;
    end
    if (pop_b) begin
      rd_ptr_b_d = ~rd_ptr_b_q;
    end
    case ({push_b, pop_b})
      2'b10:   count_b_d = count_b_q + 2'd1;
      2'b01:   count_b_d = count_b_q - 2'd1;
      default: count_b_d = count_b_q;
    endcase
  end

  // Storage is cleared too, so both heads read zero while rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_a_q  <= 2'd0;
      wr_ptr_a_q <= 1'b0;
      rd_ptr_a_q <= 1'b0;
      mem_a_q    <= '0;
      count_b_q  <= 2'd0;
      wr_ptr_b_q <= 1'b0;
      rd_ptr_b_q <= 1'b0;
      mem_b_q    <= '0;
    end else begin
      count_a_q  <= count_a_d;
      wr_ptr_a_q <= wr_ptr_a_d;
      rd_ptr_a_q <= rd_ptr_a_d;
      mem_a_q    <= mem_a_d;
      count_b_q  <= count_b_d;
      wr_ptr_b_q <= wr_ptr_b_d;
      rd_ptr_b_q <= rd_ptr_b_d;
      mem_b_q    <= mem_b_d;
    end
  end

endmodule

// File: tb/tb_demux2_buf.sv
// Self-checking bench for demux2_buf: per-channel scoreboard queues are filled
// as words are accepted and drained as each consumer takes its head entry.
module tb_demux2_buf;

  logic clk;
  logic rst;

  demux2_buf_if #(.WIDTH(32)) bus();

  demux2_buf #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp;
  int n_err;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic s, input logic [31:0] d,
                       input logic ar, input logic br);
    bus.in_valid = v;
    bus.sel      = s;
    bus.in_data  = d;
    bus.A_ready  = ar;
    bus.B_ready  = br;
  endtask

  // Advance the reference model by one clock and move to just after the edge.
  task automatic step();
    logic acc, pa, pb;
    acc = bus.in_valid && ((bus.sel ? qb.size() : qa.size()) != 2);
    pa  = (qa.size() != 0) && bus.A_ready;
    pb  = (qb.size() != 0) && bus.B_ready;
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (acc) begin
      if (bus.sel) qb.push_back(bus.in_data);
      else         qa.push_back(bus.in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    n_cmp++;
    if (bus.A_valid !== 1'b0 || bus.B_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL reset_valids: got A=%b B=%b expected 0 0", bus.A_valid, bus.B_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'hDEAD0001, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'hDEAD0002, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.A_valid !== 1'b1) begin
      n_err++; $display("[TB] FAIL prefill_full: got ready=%b A_valid=%b expected 0 1", bus.in_ready, bus.A_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.A_valid !== 1'b0 || bus.B_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL midreset_valids: got A=%b B=%b expected 0 0", bus.A_valid, bus.B_valid);
    end
    n_cmp++;
    if (bus.A_out !== 32'h0 || bus.B_out !== 32'h0) begin
      n_err++; $display("[TB] FAIL midreset_outs: got A=%h B=%h expected 0 0", bus.A_out, bus.B_out);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL midreset_in_ready: got %b expected 1", bus.in_ready);
    end
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_route();
    drive(1'b1, 1'b0, 32'h3F800000, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.A_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL route_idle: got ready=%b A_valid=%b expected 1 0", bus.in_ready, bus.A_valid);
    end
    step();
    drive(1'b1, 1'b1, 32'h40000000, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus.A_valid !== 1'b1 || bus.A_out !== 32'h3F800000 || bus.B_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL route_a: got A_valid=%b A_out=%h B_valid=%b expected 1 3f800000 0",
                        bus.A_valid, bus.A_out, bus.B_valid);
    end
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus.A_valid !== 1'b0 || bus.B_valid !== 1'b1 || bus.B_out !== 32'h40000000) begin
      n_err++; $display("[TB] FAIL route_b: got A_valid=%b B_valid=%b B_out=%h expected 0 1 40000000",
                        bus.A_valid, bus.B_valid, bus.B_out);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.B_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL route_b_pulse: got B_valid=%b expected 0", bus.B_valid);
    end
    step();
  endtask

  task automatic test_fill_backpressure();
    drive(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 32'h22222222, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("[TB] FAIL fill_ready_sel0: got %b expected 0", bus.in_ready);
    end
    bus.sel = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL fill_ready_sel1: got %b expected 1", bus.in_ready);
    end
    step();
    drive(1'b1, 1'b1, 32'h33333333, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus.B_valid !== 1'b1 || bus.B_out !== 32'h33333333) begin
      n_err++; $display("[TB] FAIL fill_b_bypass: got B_valid=%b B_out=%h expected 1 33333333", bus.B_valid, bus.B_out);
    end
    n_cmp++;
    if (bus.A_valid !== 1'b1 || bus.A_out !== 32'h11111111) begin
      n_err++; $display("[TB] FAIL fill_a_first: got A_valid=%b A_out=%h expected 1 11111111", bus.A_valid, bus.A_out);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.A_valid !== 1'b1 || bus.A_out !== 32'h22222222 || bus.B_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL fill_a_second: got A_valid=%b A_out=%h B_valid=%b expected 1 22222222 0",
                        bus.A_valid, bus.A_out, bus.B_valid);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.A_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL fill_a_drained: got A_valid=%b expected 0", bus.A_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_head;
    drive(1'b1, 1'b0, 32'h000000A5, 1'b0, 1'b1);
    step();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, i, 1'b1, 1'b1);
      exp_head = (i == 1) ? 32'h000000A5 : (i - 1);
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.A_valid !== 1'b1 || bus.A_out !== exp_head) begin
        n_err++; $display("[TB] FAIL b2b_cycle%0d: got ready=%b A_valid=%b A_out=%h expected 1 1 %h",
                          i, bus.in_ready, bus.A_valid, bus.A_out, exp_head);
      end
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus.A_valid !== 1'b1 || bus.A_out !== 32'd8) begin
      n_err++; $display("[TB] FAIL b2b_last: got A_valid=%b A_out=%h expected 1 00000008", bus.A_valid, bus.A_out);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.A_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL b2b_drained: got A_valid=%b expected 0", bus.A_valid);
    end
  endtask

  task automatic test_full_with_pop();
    drive(1'b1, 1'b0, 32'h00000055, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 32'h00000066, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 32'h00000077, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.A_out !== 32'h00000055) begin
      n_err++; $display("[TB] FAIL fullpop_refuse: got ready=%b A_out=%h expected 0 00000055", bus.in_ready, bus.A_out);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.A_out !== 32'h00000066) begin
      n_err++; $display("[TB] FAIL fullpop_after: got ready=%b A_out=%h expected 1 00000066", bus.in_ready, bus.A_out);
    end
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bus.A_valid !== 1'b1 || bus.A_out !== 32'h00000077) begin
      n_err++; $display("[TB] FAIL fullpop_third: got A_valid=%b A_out=%h expected 1 00000077", bus.A_valid, bus.A_out);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.A_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL fullpop_drained: got A_valid=%b expected 0", bus.A_valid);
    end
  endtask

  task automatic test_random_soak();
    logic exp_ready;
    int   soak_err;
    soak_err = 0;
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      @(negedge clk);
      exp_ready = (bus.sel ? qb.size() : qa.size()) != 2;
      n_cmp++;
      if (bus.in_ready !== exp_ready) begin
        n_err++; soak_err++;
        if (soak_err < 10) $display("[TB] FAIL soak_ready c%0d: got %b expected %b", c, bus.in_ready, exp_ready);
      end
      n_cmp++;
      if (bus.A_valid !== (qa.size() != 0) || (qa.size() != 0 && bus.A_out !== qa[0])) begin
        n_err++; soak_err++;
        if (soak_err < 10) $display("[TB] FAIL soak_chan_a c%0d: got valid=%b out=%h expected valid=%b out=%h",
                                    c, bus.A_valid, bus.A_out, qa.size() != 0, (qa.size() != 0) ? qa[0] : 32'h0);
      end
      n_cmp++;
      if (bus.B_valid !== (qb.size() != 0) || (qb.size() != 0 && bus.B_out !== qb[0])) begin
        n_err++; soak_err++;
        if (soak_err < 10) $display("[TB] FAIL soak_chan_b c%0d: got valid=%b out=%h expected valid=%b out=%h",
                                    c, bus.B_valid, bus.B_out, qb.size() != 0, (qb.size() != 0) ? qb[0] : 32'h0);
      end
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step();
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.A_valid !== 1'b0 || bus.B_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL soak_drain: got A=%b B=%b expected 0 0", bus.A_valid, bus.B_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single_route();
    test_fill_backpressure();
    test_back_to_back();
    test_full_with_pop();
    test_random_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
